// File: rtl/CustomTypes.sv
// Shared reorder-buffer types: entry layout and the default number of entries.
package CustomTypes;
    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned REG_W     = 6;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              tag;
        logic [REG_W-1:0]  arn;
        logic [REG_W-1:0]  rrn;
        logic [DATA_W-1:0] data;
    } RobEntry;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, captures results from two CDBs,
// retires the oldest finished non-speculative entry and squashes speculative ones.
module reorder_buffer
    import CustomTypes::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [5:0]             alloc_arn,
    input  logic [5:0]             alloc_rrn,
    input  logic                   alloc_tag,
    input  logic                   cdb1_we,
    input  logic [5:0]             cdb1_rrn,
    input  logic [31:0]            cdb1_data,
    input  logic                   cdb2_we,
    input  logic [5:0]             cdb2_rrn,
    input  logic [31:0]            cdb2_data,
    input  logic                   delete_tagged,
    input  logic                   clear_tags,
    output logic                   commit_we,
    output logic [5:0]             commit_arn,
    output logic [5:0]             commit_rrn,
    output logic [31:0]            commit_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    RobEntry           entries_q [DEPTH];
    RobEntry           entries_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              commit_we_q, commit_we_d;
    logic [5:0]        commit_arn_q, commit_arn_d;
    logic [5:0]        commit_rrn_q, commit_rrn_d;
    logic [31:0]       commit_data_q, commit_data_d;

    RobEntry           head_e;
    logic              alloc_fire;
    logic              commit_fire;
    logic [CNT_W-1:0]  ntag;

    // Acceptance depends only on registered occupancy, so a same-cycle commit never frees a slot early.
    assign alloc_ready = !full_q && !delete_tagged;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign head_e      = entries_q[head_q];
    assign commit_fire = head_e.valid && head_e.done && !head_e.tag;

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        commit_we_d   = 1'b0;
        commit_arn_d  = '0;
        commit_rrn_d  = '0;
        commit_data_d = '0;
        ntag          = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[PTR_W'(i)].valid && !entries_q[PTR_W'(i)].done) begin
                if (cdb1_we && entries_q[PTR_W'(i)].rrn == cdb1_rrn) begin
                    entries_d[PTR_W'(i)].done = 1'b1;
                    entries_d[PTR_W'(i)].data = cdb1_data;
                end else if (cdb2_we && entries_q[PTR_W'(i)].rrn == cdb2_rrn) begin
                    entries_d[PTR_W'(i)].done = 1'b1;
                    entries_d[PTR_W'(i)].data = cdb2_data;
                end
            end
            if (entries_q[PTR_W'(i)].valid && entries_q[PTR_W'(i)].tag) begin
                if (delete_tagged) begin
                    entries_d[PTR_W'(i)] = '0;
                    ntag                 = ntag + CNT_W'(1);
                end else if (clear_tags) begin
                    entries_d[PTR_W'(i)].tag = 1'b0;
                end
            end
        end

        if (commit_fire) begin
            commit_we_d       = 1'b1;
            commit_arn_d      = head_e.arn;
            commit_rrn_d      = head_e.rrn;
            commit_data_d     = head_e.data;
            entries_d[head_q] = '0;
            head_d            = head_q + PTR_W'(1);
        end

        // Tagged entries sit contiguously at the tail, so squashing just rewinds tail by their number.
        if (delete_tagged) begin
            tail_d = tail_q - PTR_W'(ntag);
        end else if (alloc_fire) begin
            entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, tag: alloc_tag,
                                  arn: alloc_arn, rrn: alloc_rrn, data: '0};
            tail_d            = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire) - ntag;
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PTR_W'(i)] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            commit_we_q   <= 1'b0;
            commit_arn_q  <= '0;
            commit_rrn_q  <= '0;
            commit_data_q <= '0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            commit_we_q   <= commit_we_d;
            commit_arn_q  <= commit_arn_d;
            commit_rrn_q  <= commit_rrn_d;
            commit_data_q <= commit_data_d;
        end
    end

    assign commit_we   = commit_we_q;
    assign commit_arn  = commit_arn_q;
    assign commit_rrn  = commit_rrn_q;
    assign commit_data = commit_data_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of in-order retirement.
module tb_reorder_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_ready, alloc_tag;
    logic [5:0]  alloc_arn, alloc_rrn;
    logic        cdb1_we, cdb2_we;
    logic [5:0]  cdb1_rrn, cdb2_rrn;
    logic [31:0] cdb1_data, cdb2_data;
    logic        delete_tagged, clear_tags;
    logic        commit_we;
    logic [5:0]  commit_arn, commit_rrn;
    logic [31:0] commit_data;
    logic [4:0]  count;
    logic        full, empty;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_arn    (alloc_arn),
        .alloc_rrn    (alloc_rrn),
        .alloc_tag    (alloc_tag),
        .cdb1_we      (cdb1_we),
        .cdb1_rrn     (cdb1_rrn),
        .cdb1_data    (cdb1_data),
        .cdb2_we      (cdb2_we),
        .cdb2_rrn     (cdb2_rrn),
        .cdb2_data    (cdb2_data),
        .delete_tagged(delete_tagged),
        .clear_tags   (clear_tags),
        .commit_we    (commit_we),
        .commit_arn   (commit_arn),
        .commit_rrn   (commit_rrn),
        .commit_data  (commit_data),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tag;
        logic        done;
        logic [5:0]  arn;
        logic [5:0]  rrn;
        logic [31:0] data;
    } ment_t;

    ment_t mq[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    spec  = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        alloc_valid   = 1'b0;
        alloc_arn     = '0;
        alloc_rrn     = '0;
        alloc_tag     = 1'b0;
        cdb1_we       = 1'b0;
        cdb1_rrn      = '0;
        cdb1_data     = '0;
        cdb2_we       = 1'b0;
        cdb2_rrn      = '0;
        cdb2_data     = '0;
        delete_tagged = 1'b0;
        clear_tags    = 1'b0;
    endtask

    // One clock: check ready, advance the model with the current inputs, check registered outputs.
    task automatic step();
        ment_t ce;
        ment_t ne;
        ment_t keep[$];
        bit    cm;
        bit    rdy;
        @(negedge clk);
        rdy = (mq.size() < DEPTH) && !delete_tagged;
        chk_eq("alloc_ready", 32'(alloc_ready), 32'(rdy));
        ce = '{default: '0};
        cm = (mq.size() > 0) && mq[0].done && !mq[0].tag;
        if (cm) ce = mq[0];
        foreach (mq[i]) begin
            if (!mq[i].done) begin
                if (cdb1_we && mq[i].rrn == cdb1_rrn) begin
                    mq[i].done = 1'b1;
                    mq[i].data = cdb1_data;
                end else if (cdb2_we && mq[i].rrn == cdb2_rrn) begin
                    mq[i].done = 1'b1;
                    mq[i].data = cdb2_data;
                end
            end
        end
        if (cm) void'(mq.pop_front());
        if (delete_tagged) begin
            foreach (mq[i]) if (!mq[i].tag) keep.push_back(mq[i]);
            mq   = keep;
            spec = 1'b0;
        end else if (clear_tags) begin
            foreach (mq[i]) mq[i].tag = 1'b0;
            spec = 1'b0;
        end
        if (alloc_valid && rdy) begin
            ne.tag  = alloc_tag;
            ne.done = 1'b0;
            ne.arn  = alloc_arn;
            ne.rrn  = alloc_rrn;
            ne.data = '0;
            mq.push_back(ne);
            if (alloc_tag) spec = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_eq("commit_we", 32'(commit_we), 32'(cm));
        chk_eq("commit_arn", 32'(commit_arn), 32'(ce.arn));
        chk_eq("commit_rrn", 32'(commit_rrn), 32'(ce.rrn));
        chk_eq("commit_data", commit_data, ce.data);
        chk_eq("count", 32'(count), 32'(mq.size()));
        chk_eq("full", 32'(full), 32'(mq.size() == DEPTH));
        chk_eq("empty", 32'(empty), 32'(mq.size() == 0));
        drive_idle();
    endtask

    task automatic do_alloc(input logic [5:0] arn, input logic [5:0] rrn, input logic tag);
        alloc_valid = 1'b1;
        alloc_arn   = arn;
        alloc_rrn   = rrn;
        alloc_tag   = tag;
        step();
    endtask

    task automatic do_cdb(input logic [5:0] rrn, input logic [31:0] data);
        cdb1_we   = 1'b1;
        cdb1_rrn  = rrn;
        cdb1_data = data;
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        #2;
        chk_eq("rst_count", 32'(count), 32'd0);
        chk_eq("rst_empty", 32'(empty), 32'd1);
        chk_eq("rst_full", 32'(full), 32'd0);
        chk_eq("rst_commit_we", 32'(commit_we), 32'd0);
        chk_eq("rst_commit_data", commit_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single instruction: allocate, result, retire one cycle later
        do_alloc(6'd5, 6'd40, 1'b0);
        do_cdb(6'd40, 32'hDEADBEEF);
        step();
        chk_eq("s1_we", 32'(commit_we), 32'd1);
        chk_eq("s1_arn", 32'(commit_arn), 32'd5);
        chk_eq("s1_rrn", 32'(commit_rrn), 32'd40);
        chk_eq("s1_data", commit_data, 32'hDEADBEEF);
        chk_eq("s1_empty", 32'(empty), 32'd1);

        // Out-of-order completion, in-order retirement on consecutive cycles
        for (int k = 0; k < 3; k++) do_alloc(6'(k + 1), 6'(33 + k), 1'b0);
        for (int k = 2; k >= 0; k--) do_cdb(6'(33 + k), 32'(100 + k));
        for (int k = 0; k < 3; k++) begin
            step();
            chk_eq("order_we", 32'(commit_we), 32'd1);
            chk_eq("order_rrn", 32'(commit_rrn), 32'(33 + k));
        end

        // Fill to capacity, overflow rejection, then one retirement frees a slot
        for (int k = 0; k < 16; k++) do_alloc(6'(k + 1), 6'(32 + k), 1'b0);
        chk_eq("fill_full", 32'(full), 32'd1);
        alloc_valid = 1'b1; alloc_rrn = 6'd50; alloc_arn = 6'd20;
        step();
        chk_eq("fill_drop", 32'(count), 32'd16);
        alloc_valid = 1'b1; alloc_rrn = 6'd50; alloc_arn = 6'd20;
        cdb1_we = 1'b1; cdb1_rrn = 6'd32; cdb1_data = 32'h55;
        step();
        alloc_valid = 1'b1; alloc_rrn = 6'd50; alloc_arn = 6'd20;
        step();
        chk_eq("fill_after_commit", 32'(count), 32'd15);
        do_alloc(6'd20, 6'd50, 1'b0);
        chk_eq("fill_refill", 32'(count), 32'd16);
        for (int k = 1; k <= 16; k++) do_cdb((k < 16) ? 6'(32 + k) : 6'd50, 32'(k * 7));
        for (int k = 0; k < 20; k++) step();
        chk_eq("fill_drained", 32'(empty), 32'd1);

        // Squash speculative entries; the next allocation reuses the freed slot
        do_alloc(6'd1, 6'd32, 1'b0);
        do_alloc(6'd2, 6'd33, 1'b1);
        do_alloc(6'd3, 6'd34, 1'b1);
        delete_tagged = 1'b1;
        step();
        chk_eq("del_count", 32'(count), 32'd1);
        do_alloc(6'd4, 6'd37, 1'b0);
        do_cdb(6'd37, 32'h37);
        do_cdb(6'd32, 32'h32);
        step();
        chk_eq("del_first", 32'(commit_rrn), 32'd32);
        step();
        chk_eq("del_second", 32'(commit_rrn), 32'd37);

        // Speculative finished head waits for resolution
        do_alloc(6'd6, 6'd36, 1'b1);
        do_cdb(6'd36, 32'h36);
        step();
        chk_eq("tag_stall", 32'(commit_we), 32'd0);
        clear_tags = 1'b1;
        step();
        step();
        chk_eq("tag_release", 32'(commit_rrn), 32'd36);

        // Both buses hit the same entry: cdb1 has priority
        do_alloc(6'd7, 6'd40, 1'b0);
        cdb1_we = 1'b1; cdb1_rrn = 6'd40; cdb1_data = 32'h1;
        cdb2_we = 1'b1; cdb2_rrn = 6'd40; cdb2_data = 32'h2;
        step();
        step();
        chk_eq("cdb_prio", commit_data, 32'h1);

        // Reset with a retirement pending drops everything silently
        do_alloc(6'd8, 6'd41, 1'b0);
        do_alloc(6'd9, 6'd42, 1'b0);
        do_cdb(6'd41, 32'h41);
        reset = 1'b1;
        #1;
        chk_eq("mrst_count", 32'(count), 32'd0);
        chk_eq("mrst_empty", 32'(empty), 32'd1);
        chk_eq("mrst_we", 32'(commit_we), 32'd0);
        @(posedge clk);
        #1;
        chk_eq("mrst_we_edge", 32'(commit_we), 32'd0);
        reset = 1'b0;
        mq.delete();
        spec = 1'b0;
        step();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            alloc_valid   = ($urandom_range(0, 9) < 7);
            alloc_arn     = 6'($urandom_range(1, 31));
            alloc_rrn     = 6'($urandom_range(32, 47));
            alloc_tag     = spec ? 1'b1 : ($urandom_range(0, 5) == 0);
            cdb1_we       = 1'($urandom_range(0, 1));
            cdb1_rrn      = 6'($urandom_range(32, 47));
            cdb1_data     = $urandom();
            cdb2_we       = 1'($urandom_range(0, 1));
            cdb2_rrn      = 6'($urandom_range(32, 47));
            cdb2_data     = $urandom();
            delete_tagged = spec && ($urandom_range(0, 15) == 0);
            clear_tags    = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two).
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have the following ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_ready  out  1  entry accepted this cycle
- alloc_arn  in  6  architectural destination (1..31)
- alloc_rrn  in  6  renamed destination (32..63)
- alloc_tag  in  1  speculative (post-branch) instruction
- cdb1_we, cdb2_we  in  1  exec result valid
- cdb1_rrn, cdb2_rrn  in  6  producing renamed register
- cdb1_data, cdb2_data  in  32  result value
- delete_tagged  in  1  discard speculative entries
- clear_tags  in  1  speculation resolved correct
- commit_we  out  1  retire write to register file
- commit_arn  out  6  retired architectural register
- commit_rrn  out  6  retired renamed register (freed by register file)
- commit_data  out  32  retired value
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH, count==0

Function
REQ-004 SHALL be a circular FIFO with head (oldest) and tail pointers wrapping modulo DEPTH; entry = {valid, done, tag, arn, rrn, data}.
REQ-005 alloc_ready SHALL be combinational: !full && !delete_tagged.
REQ-006 On alloc_valid && alloc_ready, SHALL write {1,0,alloc_tag,alloc_arn,alloc_rrn,0} at tail and increment tail.
REQ-007 Every valid, not-done entry whose rrn equals cdbN_rrn with cdbN_we SHALL set done=1 and data=cdbN_data at the edge.
REQ-008 If both buses match one entry, cdb1 SHALL win; an entry allocated in the same cycle SHALL NOT capture that cycle's CDB.
REQ-009 When head is valid, done and tag==0, SHALL register commit_we=1 with that entry's arn/rrn/data, clear the entry and advance head; at most one commit per cycle.
REQ-010 Commit latency SHALL be one cycle: CDB capture at edge N gives commit_we high after edge N+1 if the entry is head.
REQ-011 commit_we SHALL be a single-cycle pulse per retired entry; commit_arn/rrn/data SHALL be 0 when commit_we=0.
REQ-012 A tagged head SHALL stall commit until clear_tags or delete_tagged.
REQ-013 delete_tagged SHALL invalidate every tagged entry (contiguous at tail) and move tail to the oldest tagged entry; commit of an untagged head SHALL still proceed that cycle.
REQ-014 clear_tags SHALL clear tag of all existing entries; an entry allocated in the same cycle keeps alloc_tag.
REQ-015 If delete_tagged and clear_tags are both high, delete_tagged SHALL win.
REQ-016 Simultaneous allocate and commit SHALL leave count unchanged; full with commit SHALL still reject allocate (alloc_ready from registered count).
REQ-017 count/full/empty SHALL reflect state after the last edge.

Reset
REQ-018 Reset SHALL immediately clear all entry valid bits, head=tail=0, count=0, empty=1, full=0, commit_we=0, commit_arn/rrn/data=0.
REQ-019 Reset mid-operation SHALL drop all in-flight entries without any commit pulse.

Structure
REQ-020 The entry struct RobEntry and constant ROB_DEPTH SHALL live in the shared CustomTypes package.
REQ-021 SHALL be a single module with no sub-modules.

Verification
REQ-022 Alloc arn=5/rrn=40; cdb1 rrn=40 data=0xDEADBEEF -> next cycle commit_we=1, arn=5, rrn=40, data=0xDEADBEEF; empty=1 after.
REQ-023 Alloc rrn 33,34,35; results arrive 35,34,33 -> commits strictly in order 33,34,35 on consecutive cycles.
REQ-024 Fill 16 entries -> full=1, alloc_ready=0; 17th request dropped; one commit -> alloc accepted next cycle; tail wraps to 0.
REQ-025 Alloc untagged rrn=32, tagged rrn=33,34; delete_tagged -> count=1, only rrn=32 commits; new alloc lands in old rrn=33 slot.
REQ-026 Tagged done head rrn=36 -> no commit; clear_tags -> commit rrn=36 next cycle.
REQ-027 cdb1 and cdb2 both rrn=40, data 0x1/0x2 -> committed data=0x1; reset asserted mid-fill -> count=0, no commit_we.
